alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single combinational ALU between two requesters (e.g. execute unit, address unit).
//  Round-robin arbitration; valid/ready handshake on each request port and on the shared response port.
//  Operands and opcode are registered before they reach the ALU; the ALU result is registered before it is returned.
//  Sits between the requesters and the ALU. Drives operand1/operand2/opCode; samples result.
// PARAMETERS
//  WIDTH    32   operand/result width; must match the ALU
//  OPW      6    opcode width; must match the ALU
//  MAX_OP   4    highest legal opcode (ADD=0 SUB=1 AND=2 OR=3 XOR=4)
// PORTS
//  clk           in   1      system clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  req0_valid    in   1      requester 0 has an operation
//  req0_ready    out  1      requester 0 operation accepted this cycle
//  req0_op1      in   WIDTH  requester 0 operand1
//  req0_op2      in   WIDTH  requester 0 operand2
//  req0_opcode   in   OPW    requester 0 opcode
//  req1_*        -    -      same as req0_*, for requester 1
//  alu_operand1  out  WIDTH  to ALU operand1 (registered)
//  alu_operand2  out  WIDTH  to ALU operand2 (registered)
//  alu_opCode    out  OPW    to ALU opCode (registered)
//  alu_result    in   WIDTH  from ALU result (combinational)
//  rsp_valid     out  1      response available
//  rsp_ready     in   1      consumer accepts response
//  rsp_id        out  1      requester that issued the response's operation
//  rsp_result    out  WIDTH  registered ALU result
//  rsp_illegal   out  1      opcode was > MAX_OP (result is the ALU default, 0)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; last_grant=1, so req0 wins the first tie.
//   All outputs and registers are cleared to 0, including rsp_valid, req*_ready and alu_*.
//   Reset mid-operation abandons the operation silently. No response is produced.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//  IDLE:
//   - Grant selection: only one valid -> that one wins.
//     Both valid -> the requester != last_grant wins.
//     Neither valid -> stay in IDLE.
//   - reqN_ready=1 combinationally, only for the selected N and only in IDLE. At most one ready per cycle.
//   - On handshake (valid&ready):
//     - Latch op1/op2/opcode into the alu_* registers.
//     - Latch id=N; last_grant<=N.
//     - illegal <= (opcode > MAX_OP).
//     - Go to EXEC.
//  EXEC (1 cycle):
//   - ALU inputs are stable.
//   - rsp_result<=alu_result; rsp_id, rsp_illegal loaded; rsp_valid<=1.
//   - Go to RESP.
//  RESP:
//   - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
//   - On rsp_ready=1: rsp_valid<=0 and go to IDLE. No new grant in that same cycle.
//  Latency: request accept edge -> rsp_valid high 2 cycles later.
//   Throughput is at most one op per 3 cycles.
//  alu_* hold their last values outside EXEC. They change only on a handshake.
//  reqN fields must be held stable by the requester while valid=1 and ready=0.
//   Dropping valid before ready is permitted; nothing is latched.
//  Width: no carry/overflow output; ADD/SUB wrap modulo 2^WIDTH, as the ALU does.
//  Starvation: under continuous contention, grants strictly alternate 0,1,0,1...
// TESTING
//  1. Reset, req0 only: ADD 5+7.
//     -> req0_ready=1 in cycle 0; rsp_valid at cycle 2 with result 12, id 0, illegal 0.
//  2. Both valid continuously (req0 SUB 10-3, req1 XOR F0^0F), rsp_ready=1.
//     -> grants in order 0,1,0,1; results 7, FF; each grant 3 cycles apart.
//  3. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
//     -> rsp_result/id held stable; req*_ready stays 0 until the response is taken.
//  4. Illegal opcode 6'h3F with operands 1, 2.
//     -> rsp_result=0, rsp_illegal=1, FSM returns to IDLE normally.
//  5. Wrap: ADD FFFFFFFF+1 -> 0; SUB 0-1 -> FFFFFFFF.
//  6. Assert rst_n=0 while in EXEC.
//     -> rsp_valid=0 immediately; after release, req0 wins a tie.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundles the two request ports, the ALU-facing operand/result wires and the shared response port.
// Handshake rule: a transfer occurs on a rising clk edge where valid and ready are both 1; payload stays stable while valid=1 and ready=0.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 6
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_op1;
  logic [WIDTH-1:0] req0_op2;
  logic [OPW-1:0]   req0_opcode;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_op1;
  logic [WIDTH-1:0] req1_op2;
  logic [OPW-1:0]   req1_opcode;

  logic [WIDTH-1:0] alu_operand1;
  logic [WIDTH-1:0] alu_operand2;
  logic [OPW-1:0]   alu_opCode;
  logic [WIDTH-1:0] alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_illegal;

  logic [1:0]       dbg_state;

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_opcode,
    output req0_ready,
    input  req1_valid, req1_op1, req1_op2, req1_opcode,
    output req1_ready,
    output alu_operand1, alu_operand2, alu_opCode,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_result, rsp_illegal,
    input  rsp_ready,
    output dbg_state
  );

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_opcode,
    input  req0_ready,
    output req1_valid, req1_op1, req1_op2, req1_opcode,
    input  req1_ready,
    input  alu_operand1, alu_operand2, alu_opCode,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_result, rsp_illegal,
    output rsp_ready,
    input  dbg_state
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered toward the ALU, and the result is registered back onto a valid/ready response port.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int OPW    = 6,
  parameter int MAX_OP = 4
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant;
  logic             id_q;
  logic             illegal_q;
  logic [WIDTH-1:0] operand1_q;
  logic [WIDTH-1:0] operand2_q;
  logic [OPW-1:0]   opcode_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_illegal_q;
  logic             sel0, sel1;
  logic             take0, take1;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      sel0 = last_grant;
      sel1 = !last_grant;
    end else begin
      sel0 = bus.req0_valid;
      sel1 = bus.req1_valid;
    end
  end

  // Gated by rst_n so no ready is visible while reset is held.
  assign bus.req0_ready = rst_n && (state_q == IDLE) && sel0;
  assign bus.req1_ready = rst_n && (state_q == IDLE) && sel1;
  assign take0 = bus.req0_valid && bus.req0_ready;
  assign take1 = bus.req1_valid && bus.req1_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take0 || take1) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant    <= 1'b1;
      id_q          <= 1'b0;
      illegal_q     <= 1'b0;
      operand1_q    <= '0;
      operand2_q    <= '0;
      opcode_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      if (take0) begin
        operand1_q <= bus.req0_op1;
        operand2_q <= bus.req0_op2;
        opcode_q   <= bus.req0_opcode;
        id_q       <= 1'b0;
        last_grant <= 1'b0;
        illegal_q  <= (bus.req0_opcode > OPW'(MAX_OP));
      end else if (take1) begin
        operand1_q <= bus.req1_op1;
        operand2_q <= bus.req1_op2;
        opcode_q   <= bus.req1_opcode;
        id_q       <= 1'b1;
        last_grant <= 1'b1;
        illegal_q  <= (bus.req1_opcode > OPW'(MAX_OP));
      end

      // The ALU output is captured during EXEC, when its inputs have had a full cycle to settle.
      if (state_q == EXEC) begin
        rsp_result_q  <= bus.alu_result;
        rsp_id_q      <= id_q;
        rsp_illegal_q <= illegal_q;
        rsp_valid_q   <= 1'b1;
      end else if (state_q == RESP && bus.rsp_ready) begin
        rsp_valid_q   <= 1'b0;
      end
    end
  end

  assign bus.alu_operand1 = operand1_q;
  assign bus.alu_operand2 = operand2_q;
  assign bus.alu_opCode   = opcode_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_illegal  = rsp_illegal_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter with a behavioural ALU and a queue-based reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge or just after it.
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 6;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_asserts;
  int   n_fail;

  alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .MAX_OP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU sitting behind the arbiter
  always_comb begin
    case (bus.alu_opCode)
      6'd0:    bus.alu_result = bus.alu_operand1 + bus.alu_operand2;
      6'd1:    bus.alu_result = bus.alu_operand1 - bus.alu_operand2;
      6'd2:    bus.alu_result = bus.alu_operand1 & bus.alu_operand2;
      6'd3:    bus.alu_result = bus.alu_operand1 | bus.alu_operand2;
      6'd4:    bus.alu_result = bus.alu_operand1 ^ bus.alu_operand2;
      default: bus.alu_result = '0;
    endcase
  end

  // Scoreboard and reference model
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_id_q[$];
  logic             exp_ill_q[$];
  int               last_w;

  function automatic logic [WIDTH-1:0] model_result(logic [OPW-1:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    longint unsigned m;
    m = 64'd1 << WIDTH;
    if (op == 0) return WIDTH'((longint'(a) + longint'(b)) % m);
    if (op == 1) return WIDTH'((longint'(a) + m - longint'(b)) % m);
    if (op == 2) return a & b;
    if (op == 3) return a | b;
    if (op == 4) return a ^ b;
    return '0;
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: one full transaction starting at a falling edge with the DUT idle.
  task automatic run_op(input bit v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0, input logic [OPW-1:0] o0,
                        input bit v1, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1, input logic [OPW-1:0] o1,
                        input int bp, output int gcyc);
    int               w;
    logic [WIDTH-1:0] e_res;
    logic             e_id;
    logic             e_ill;
    logic [WIDTH-1:0] wa;
    bus.req0_valid = v0; bus.req0_op1 = a0; bus.req0_op2 = b0; bus.req0_opcode = o0;
    bus.req1_valid = v1; bus.req1_op1 = a1; bus.req1_op2 = b1; bus.req1_opcode = o1;
    #1;
    w = (v0 && v1) ? (1 - last_w) : (v0 ? 0 : 1);
    check("grant_ready0", WIDTH'(bus.req0_ready), WIDTH'(w == 0));
    check("grant_ready1", WIDTH'(bus.req1_ready), WIDTH'(w == 1));
    wa = (w == 0) ? a0 : a1;
    exp_q.push_back((w == 0) ? model_result(o0, a0, b0) : model_result(o1, a1, b1));
    exp_id_q.push_back(w[0]);
    exp_ill_q.push_back((w == 0) ? (o0 > 4) : (o1 > 4));
    last_w = w;
    gcyc = cyc;

    @(negedge clk);
    if (w == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
    #1;
    check("exec_rsp_valid", WIDTH'(bus.rsp_valid), 0);
    check("exec_ready", WIDTH'({bus.req0_ready, bus.req1_ready}), 0);
    check("exec_operand1", bus.alu_operand1, wa);

    @(negedge clk);
    e_res = exp_q.pop_front();
    e_id  = exp_id_q.pop_front();
    e_ill = exp_ill_q.pop_front();
    check("rsp_valid", WIDTH'(bus.rsp_valid), 1);
    check("rsp_result", bus.rsp_result, e_res);
    check("rsp_id", WIDTH'(bus.rsp_id), WIDTH'(e_id));
    check("rsp_illegal", WIDTH'(bus.rsp_illegal), WIDTH'(e_ill));
    for (int k = 0; k < bp; k++) begin
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_valid", WIDTH'(bus.rsp_valid), 1);
      check("bp_result", bus.rsp_result, e_res);
      check("bp_id", WIDTH'(bus.rsp_id), WIDTH'(e_id));
      check("bp_ready", WIDTH'({bus.req0_ready, bus.req1_ready}), 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_taken", WIDTH'(bus.rsp_valid), 0);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int g, gprev;
    bit rv0, rv1;
    n_asserts = 0;
    n_fail    = 0;
    last_w    = 1;
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_op1 = '0; bus.req0_op2 = '0; bus.req0_opcode = '0;
    bus.req1_valid = 1'b0; bus.req1_op1 = '0; bus.req1_op2 = '0; bus.req1_opcode = '0;
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", WIDTH'(bus.rsp_valid), 0);
    check("reset_operand1", bus.alu_operand1, 0);
    check("reset_opcode", WIDTH'(bus.alu_opCode), 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle_no_ready", WIDTH'({bus.req0_ready, bus.req1_ready}), 0);

    // Single requester: ADD 5+7
    run_op(1, 5, 7, 0, 0, 0, 0, 0, 0, g);

    // Continuous contention: grants alternate, three cycles apart
    gprev = -1;
    for (int i = 0; i < 4; i++) begin
      run_op(1, 10, 3, 1, 1, 32'hF0, 32'h0F, 4, 0, g);
      if (gprev >= 0) check("grant_spacing", WIDTH'(g - gprev), 3);
      gprev = g;
    end

    // Backpressure for 5 cycles while the other requester waits
    run_op(1, 32'h1234, 32'h1, 3, 1, 32'hAA55, 32'hFF00, 2, 5, g);

    // Illegal opcode, then normal operation afterwards
    run_op(1, 1, 2, 6'h3F, 0, 0, 0, 0, 0, g);
    run_op(0, 0, 0, 0, 1, 9, 4, 1, 0, g);

    // Wrap-around
    run_op(1, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0, g);
    run_op(0, 0, 0, 0, 1, 0, 1, 1, 0, g);

    // Randomized traffic including illegal opcodes and random backpressure
    for (int i = 0; i < 20; i++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_op(rv0, $urandom, $urandom, OPW'($urandom_range(0, 7)),
             rv1, $urandom, $urandom, OPW'($urandom_range(0, 7)),
             $urandom_range(0, 2), g);
    end

    // Reset while the operation is in EXEC
    bus.req0_valid = 1'b1; bus.req0_op1 = 32'd100; bus.req0_op2 = 32'd1; bus.req0_opcode = 6'd0;
    bus.req1_valid = 1'b1; bus.req1_op1 = 32'd200; bus.req1_op2 = 32'd2; bus.req1_opcode = 6'd1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_rsp_valid", WIDTH'(bus.rsp_valid), 0);
    check("rst_mid_ready", WIDTH'({bus.req0_ready, bus.req1_ready}), 0);
    check("rst_mid_operand1", bus.alu_operand1, 0);
    repeat (2) @(negedge clk);
    check("rst_hold_rsp_valid", WIDTH'(bus.rsp_valid), 0);
    rst_n = 1'b1;
    last_w = 1;
    run_op(1, 32'd100, 32'd1, 0, 1, 32'd200, 32'd2, 1, 0, g);
    run_op(1, 32'd100, 32'd1, 0, 1, 32'd200, 32'd2, 1, 0, g);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
